// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Turns a raw, bouncing, asynchronous push-button into clean control pulses:
// a two-flop synchronizer, an integrating debouncer producing a stable level,
// a one-cycle press pulse on every accepted press, and an optional auto-repeat
// pulse train while the button is held.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing synchronized samples needed to
//                    accept a level change
//   REPEAT_DELAY     cycles from press_pulse to the first repeat_pulse
//   REPEAT_PERIOD    cycles between successive repeat_pulse assertions
//   REPEAT_EN        0 ties repeat_pulse low and freezes the hold FSM
//                    before HELD_REPEAT
//   All timing parameters must lie in 1 .. 2^27-1.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset (release synchronized
//                 externally)
//   btn_raw       raw button, active-high, asynchronous, may bounce
//   btn_level     debounced button level
//   press_pulse   one cycle high on each accepted press
//   repeat_pulse  one cycle high per auto-repeat while held
//   step_pulse    press_pulse | repeat_pulse, same timing as both
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic repeat_pulse,
    output logic step_pulse
);

    localparam int CNT_W = 27;

    // Counters compare against "last" values so that a match on the current
    // count means the target is reached on this very edge.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] HELD_DELAY  = 2'd1;
    localparam logic [1:0] HELD_REPEAT = 2'd2;

    // -------------------------------------------------------------------------
    // Stage p0/p1: two-flop synchronizer for the asynchronous button input
    // -------------------------------------------------------------------------
    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: integrate disagreement between synchronized input and level
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] deb_cnt_nxt;
    logic             level_nxt;
    logic             rise_nxt;

    always_comb begin
        deb_cnt_nxt = '0;
        level_nxt   = btn_level;
        if (sync_p1 != btn_level) begin
            // ">=" keeps the counter from ever running past the threshold.
            if (deb_cnt >= DEB_LAST) begin
                level_nxt   = ~btn_level;
                deb_cnt_nxt = '0;
            end else begin
                deb_cnt_nxt = deb_cnt + CNT_ONE;
            end
        end
    end

    assign rise_nxt = level_nxt & ~btn_level;

    // -------------------------------------------------------------------------
    // Hold FSM: press -> delay -> periodic repeat, release always wins
    // -------------------------------------------------------------------------
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;
    logic             repeat_nxt;

    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold_cnt;
        repeat_nxt = 1'b0;
        if (!level_nxt) begin
            // Release (or still released) forces IDLE on the same edge, which
            // also suppresses a repeat that would otherwise be due now.
            state_nxt = IDLE;
            hold_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    hold_nxt = '0;
                    if (rise_nxt) begin
                        state_nxt = HELD_DELAY;
                    end
                end
                HELD_DELAY: begin
                    if (hold_cnt >= DLY_LAST) begin
                        if (REPEAT_EN != 0) begin
                            repeat_nxt = 1'b1;
                            state_nxt  = HELD_REPEAT;
                            hold_nxt   = '0;
                        end else begin
                            // Repeat disabled: park here with the counter
                            // saturated rather than letting it wrap.
                            hold_nxt = hold_cnt;
                        end
                    end else begin
                        hold_nxt = hold_cnt + CNT_ONE;
                    end
                end
                HELD_REPEAT: begin
                    if (hold_cnt >= PER_LAST) begin
                        repeat_nxt = 1'b1;
                        hold_nxt   = '0;
                    end else begin
                        hold_nxt = hold_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Stage p2: registered state, level and pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt      <= '0;
            btn_level    <= 1'b0;
            state        <= IDLE;
            hold_cnt     <= '0;
            press_pulse  <= 1'b0;
            repeat_pulse <= 1'b0;
            step_pulse   <= 1'b0;
        end else begin
            deb_cnt      <= deb_cnt_nxt;
            btn_level    <= level_nxt;
            state        <= state_nxt;
            hold_cnt     <= hold_nxt;
            press_pulse  <= rise_nxt;
            repeat_pulse <= repeat_nxt;
            step_pulse   <= rise_nxt | repeat_nxt;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Drives two instances (auto-repeat enabled and disabled) from the same
// button and reset, compares both against a timeline model every cycle, and
// pins key instants with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic btn_raw = 1'b0;

    logic lvl, prs, rpt, stp;
    logic lvl0, prs0, rpt0, stp0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_EN      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (lvl),
        .press_pulse (prs),
        .repeat_pulse(rpt),
        .step_pulse  (stp)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_EN      (0)
    ) dut_norep (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (lvl0),
        .press_pulse (prs0),
        .repeat_pulse(rpt0),
        .step_pulse  (stp0)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Timeline model: what the DUT sampled at each edge, then the outputs
    // derived from edge indices since reset.
    // -------------------------------------------------------------------------
    logic raw_at_edge = 1'b0;
    logic rst_at_edge = 1'b0;

    always @(posedge clk) begin
        raw_at_edge <= btn_raw;
        rst_at_edge <= rst_n;
    end

    bit raw_hist [0:4095];
    int edge_n       = 0;
    int run_len      = 0;
    int press_edge   = 0;
    bit m_level      = 1'b0;
    bit m_press      = 1'b0;
    bit m_rep        = 1'b0;
    bit was_level    = 1'b0;
    bit seen         = 1'b0;
    int since_press  = 0;

    initial begin : model_and_compare
        forever begin
            @(negedge clk);
            if (!rst_n || !rst_at_edge) begin
                edge_n     = 0;
                run_len    = 0;
                press_edge = 0;
                m_level    = 1'b0;
                m_press    = 1'b0;
                m_rep      = 1'b0;
            end else begin
                edge_n++;
                raw_hist[edge_n % 4096] = raw_at_edge;
                // The input seen by the debouncer lags the pin by two edges.
                seen      = (edge_n >= 3) ? raw_hist[(edge_n - 2) % 4096] : 1'b0;
                was_level = m_level;
                run_len   = (seen != m_level) ? run_len + 1 : 0;
                if (run_len == DEB) begin
                    m_level = ~m_level;
                    run_len = 0;
                end
                m_press = m_level && !was_level;
                if (m_press) press_edge = edge_n;
                m_rep = 1'b0;
                if (m_level && was_level) begin
                    since_press = edge_n - press_edge;
                    m_rep = (since_press >= RD) && (((since_press - RD) % RP) == 0);
                end
            end
            chk("level",        lvl,  m_level);
            chk("press",        prs,  m_press);
            chk("repeat",       rpt,  m_rep);
            chk("step",         stp,  m_press | m_rep);
            chk("press_rep_excl", prs & rpt, 1'b0);
            chk("level_norep",  lvl0, m_level);
            chk("press_norep",  prs0, m_press);
            chk("repeat_norep", rpt0, 1'b0);
            chk("step_norep",   stp0, m_press);
        end
    end

    // -------------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // -------------------------------------------------------------------------
    int press_cnt;
    int rep_cnt;
    int rep_cnt0;
    int press_cnt0;
    logic exp_r;

    initial begin : stimulus
        #1 rst_n = 1'b0;
        #2;
        chk("reset_level", lvl, 1'b0);
        chk("reset_press", prs, 1'b0);
        chk("reset_repeat", rpt, 1'b0);
        chk("reset_step", stp, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        settle(3);

        // Clean press held 6 cycles then released.
        btn_raw = 1'b1;
        settle(5);
        chk("clean_lvl_e5", lvl, 1'b0);
        settle(1);
        chk("clean_lvl_e6", lvl, 1'b1);
        chk("clean_press_e6", prs, 1'b1);
        btn_raw = 1'b0;
        settle(1);
        chk("clean_press_e7", prs, 1'b0);
        settle(4);
        chk("clean_rel_e5", lvl, 1'b1);
        settle(1);
        chk("clean_rel_e6", lvl, 1'b0);
        settle(8);

        // Bounce 1,0,1,1,0 then steady 1: press lands on edge 11.
        press_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            btn_raw = (i == 1 || i == 4) ? 1'b0 : 1'b1;
            settle(1);
            press_cnt += int'(prs);
        end
        btn_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle(1);
            press_cnt += int'(prs);
        end
        chk("bounce_lvl_e10", lvl, 1'b0);
        chk_int("bounce_no_early_press", press_cnt, 0);
        settle(1);
        chk("bounce_press_e11", prs, 1'b1);
        chk("bounce_lvl_e11", lvl, 1'b1);

        // Held: repeats at press+10,+13,...,+28.
        for (int k = 1; k <= 30; k++) begin
            settle(1);
            exp_r = (k == 10 || k == 13 || k == 16 || k == 19 ||
                     k == 22 || k == 25 || k == 28) ? 1'b1 : 1'b0;
            chk("hold_repeat", rpt, exp_r);
            chk("hold_step", stp, exp_r);
        end

        // Release so the level falls at press+37, when a repeat is also due.
        settle(1);
        chk("due_rep_p31", rpt, 1'b1);
        btn_raw = 1'b0;
        settle(3);
        chk("due_rep_p34", rpt, 1'b1);
        settle(2);
        chk("due_lvl_p36", lvl, 1'b1);
        settle(1);
        chk("due_lvl_p37", lvl, 1'b0);
        chk("due_rep_p37", rpt, 1'b0);
        chk("due_step_p37", stp, 1'b0);
        settle(10);

        // Reset pulse during HELD_REPEAT with the button held.
        btn_raw = 1'b1;
        settle(6);
        chk("rst_pre_press", prs, 1'b1);
        settle(12);
        chk("rst_pre_level", lvl, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_level", lvl, 1'b0);
        chk("rst_async_press", prs, 1'b0);
        chk("rst_async_repeat", rpt, 1'b0);
        chk("rst_async_step", stp, 1'b0);
        chk("rst_async_level_norep", lvl0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        settle(5);
        chk("rst_after_e5_press", prs, 1'b0);
        chk("rst_after_e5_level", lvl, 1'b0);
        settle(1);
        chk("rst_after_e6_press", prs, 1'b1);
        chk("rst_after_e6_level", lvl, 1'b1);
        btn_raw = 1'b0;
        settle(12);

        // 40-cycle hold after the press: one press on both, 11 repeats only
        // on the enabled instance.
        press_cnt  = 0;
        press_cnt0 = 0;
        rep_cnt    = 0;
        rep_cnt0   = 0;
        btn_raw = 1'b1;
        for (int i = 0; i < 46; i++) begin
            settle(1);
            press_cnt  += int'(prs);
            press_cnt0 += int'(prs0);
            rep_cnt    += int'(rpt);
            rep_cnt0   += int'(rpt0);
        end
        chk_int("norep_press_count", press_cnt0, 1);
        chk_int("norep_repeat_count", rep_cnt0, 0);
        chk_int("rep_press_count", press_cnt, 1);
        chk_int("rep_repeat_count", rep_cnt, 11);
        btn_raw = 1'b0;
        settle(12);
        chk("final_level", lvl, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable synchronized samples needed to accept a level change (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50000000, the number of cycles from press_pulse to the first repeat_pulse (0.5 s).
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10000000, the number of cycles between successive repeat_pulse assertions (0.1 s).
REQ-004 The block SHALL have parameter REPEAT_EN, default 1; when 0, repeat_pulse SHALL be tied low.
REQ-005 Port clk SHALL be an input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 Port rst_n SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port btn_raw SHALL be an input, 1 bit: raw push-button, active-high, asynchronous to clk, may bounce.
REQ-008 Port btn_level SHALL be an output, 1 bit: debounced button level.
REQ-009 Port press_pulse SHALL be an output, 1 bit: one-cycle pulse on each accepted press.
REQ-010 Port repeat_pulse SHALL be an output, 1 bit: one-cycle auto-repeat pulse while the button is held.
REQ-011 Port step_pulse SHALL be an output, 1 bit: press_pulse OR repeat_pulse, registered with the same timing as both.

Function
REQ-012 The block SHALL pass btn_raw through a two-stage flip-flop synchronizer before any other use.
REQ-013 The debounce counter SHALL increment each cycle the synchronized input differs from btn_level, and SHALL clear to 0 in any cycle where they match.
REQ-014 When the debounce counter reaches DEBOUNCE_CYCLES, btn_level SHALL toggle on that edge and the counter SHALL clear.
REQ-015 Latency: a clean btn_raw transition SHALL appear on btn_level exactly DEBOUNCE_CYCLES+2 rising edges later.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change btn_level.
REQ-017 press_pulse SHALL be high for exactly the first cycle in which btn_level is 1 after being 0.
REQ-018 The button release (btn_level 1->0) SHALL generate no pulse on any output.
REQ-019 The state machine SHALL have states IDLE, HELD_DELAY and HELD_REPEAT.
REQ-020 IDLE SHALL transition to HELD_DELAY on press_pulse, loading the hold counter with 0.
REQ-021 In HELD_DELAY, the first repeat_pulse SHALL occur exactly REPEAT_DELAY cycles after the press_pulse cycle, and the FSM SHALL then enter HELD_REPEAT.
REQ-022 In HELD_REPEAT, repeat_pulse SHALL recur every REPEAT_PERIOD cycles for as long as btn_level stays 1.
REQ-023 From any state, btn_level falling to 0 SHALL return the FSM to IDLE and clear the hold counter in the same cycle; no repeat_pulse SHALL fire in that cycle or later.
REQ-024 If a release and a repeat are due in the same cycle, the release SHALL win and repeat_pulse SHALL stay low.
REQ-025 press_pulse and repeat_pulse SHALL never be high in the same cycle.
REQ-026 All counters SHALL be 27 bits wide, unsigned, and SHALL never wrap; parameter values SHALL be in the range 1 to 2^27-1.
REQ-027 With REPEAT_EN=0, the FSM SHALL remain in IDLE or HELD_DELAY and SHALL never assert repeat_pulse.

Reset
REQ-028 While rst_n=0, the synchronizer stages, btn_level, press_pulse, repeat_pulse and step_pulse SHALL be 0, all counters SHALL be 0, and the FSM SHALL be in IDLE, independent of clk.
REQ-029 Asserting rst_n mid-hold SHALL abort immediately; after release of reset with the button still held, a press_pulse SHALL occur only after a full debounce (DEBOUNCE_CYCLES+2 edges).
REQ-030 Release of rst_n SHALL be synchronized by the integrating system; the block itself SHALL NOT filter it.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-031 Clean press held 6 cycles, then released -> btn_level rises at edge 6, press_pulse fires for 1 cycle at edge 6, no repeat_pulse, btn_level falls 6 edges after the release.
REQ-032 Bounce pattern 1,0,1,1,0 followed by a steady 1 -> no output activity until 4 consecutive synchronized 1s, then a single press_pulse.
REQ-033 Hold for 30 cycles after press_pulse -> repeat_pulse at +10, +13, +16, ... +28, and step_pulse matches press_pulse OR repeat_pulse on every cycle.
REQ-034 Release timed so that btn_level falls on the same cycle a repeat is due -> repeat_pulse stays 0 and the FSM returns to IDLE.
REQ-035 rst_n pulsed low for 1 cycle during HELD_REPEAT, button held -> all outputs 0 asynchronously; press_pulse re-fires 6 edges after rst_n rises.
REQ-036 REPEAT_EN=0 with a 40-cycle hold -> exactly one press_pulse and repeat_pulse constant 0.
